// File: rtl/dac_spi_multi.sv
// dac_spi_multi: multi-channel serial DAC writer. Keeps a shadow copy of the
// last code sent to each channel. A frame {command, code} goes out for any
// channel whose input differs from that copy, or which has a pending forced
// rewrite. Channels are served round-robin. All pin activity happens on
// divided tick cycles.
module dac_spi_multi #(
  parameter int N_CH     = 2,
  parameter int DATA_W   = 16,
  parameter int CMD_W    = 8,
  parameter int CMD_BASE = 'h10,
  parameter int CLK_DIV  = 25,
  parameter int SYNC_GAP = 2
) (
  input  logic                     clk_100M,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic                     force_update,
  output logic                     sclk,
  output logic                     sdata,
  output logic                     sync,
  output logic                     busy,
  output logic                     frame_done,
  output logic [2:0]               last_ch
);

  localparam int FRAME_W = DATA_W + CMD_W;
  localparam int IDX_W   = $clog2(FRAME_W);
  localparam int TC_W    = $clog2(CLK_DIV);
  localparam int GC_W    = $clog2(SYNC_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_HI, S_SHIFT_LO, S_END, S_GAP
  } state_t;

  state_t                         state_q, state_d;
  logic [TC_W-1:0]                tick_cnt_q;
  logic                           tick;
  logic [N_CH-1:0][DATA_W-1:0]    data_q;
  logic [N_CH-1:0][DATA_W-1:0]    written_q, written_d;
  logic [N_CH-1:0]                force_q, force_d;
  logic [FRAME_W-1:0]             frame_q, frame_d;
  logic [2:0]                     ch_q, ch_d;
  logic [IDX_W-1:0]               bit_idx_q, bit_idx_d;
  logic [GC_W-1:0]                gap_q, gap_d;
  logic                           sclk_q, sclk_d;
  logic                           sdata_q, sdata_d;
  logic                           sync_q, sync_d;
  logic                           done_q, done_d;
  logic [2:0]                     last_q, last_d;

  logic [N_CH-1:0]                dirty;
  logic                           found;
  logic [2:0]                     sel;
  logic [DATA_W-1:0]              code_sel;
  logic [31:0]                    cmd_full;

  assign tick = (tick_cnt_q == TC_W'(CLK_DIV - 1));

  // Free-running bit-phase divider
  always_ff @(posedge clk_100M) begin
    if (rst) tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else tick_cnt_q <= tick_cnt_q + TC_W'(1);
  end

  // A channel needs a write when its input differs from what the DAC holds
  always_comb begin
    dirty = '0;
    for (int j = 0; j < N_CH; j++)
      dirty[j] = (data_q[j] != written_q[j]) | force_q[j];
  end

  // Round-robin pick: first dirty channel starting just after the last one served
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    code_sel = '0;
    for (int k = 1; k <= N_CH; k++) begin
      for (int j = 0; j < N_CH; j++) begin
        if (!found && dirty[j] && (((int'(last_q) + k) % N_CH) == j)) begin
          found = 1'b1;
          sel   = 3'(j);
        end
      end
    end
    for (int j = 0; j < N_CH; j++)
      if (sel == 3'(j)) code_sel = data_q[j];
    cmd_full = 32'(CMD_BASE) + 32'(sel);
  end

  // Frame sequencer: next state, pin values and shadow-copy updates
  always_comb begin
    state_d   = state_q;
    written_d = written_q;
    force_d   = force_q;
    frame_d   = frame_q;
    ch_d      = ch_q;
    bit_idx_d = bit_idx_q;
    gap_d     = gap_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    sync_d    = sync_q;
    done_d    = 1'b0;
    last_d    = last_q;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            frame_d   = {cmd_full[CMD_W-1:0], code_sel};
            ch_d      = sel;
            sync_d    = 1'b0;
            sclk_d    = 1'b1;
            bit_idx_d = IDX_W'(FRAME_W - 1);
            state_d   = S_SHIFT_HI;
          end
        end
        S_SHIFT_HI: begin
          sdata_d = frame_q[bit_idx_q];
          sclk_d  = 1'b1;
          state_d = S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          sclk_d = 1'b0;
          if (bit_idx_q == '0) begin
            state_d = S_END;
          end else begin
            bit_idx_d = bit_idx_q - IDX_W'(1);
            state_d   = S_SHIFT_HI;
          end
        end
        S_END: begin
          sync_d  = 1'b1;
          sclk_d  = 1'b1;
          sdata_d = 1'b0;
          for (int j = 0; j < N_CH; j++) begin
            if (ch_q == 3'(j)) begin
              written_d[j] = frame_q[DATA_W-1:0];
              force_d[j]   = 1'b0;
            end
          end
          last_d  = ch_q;
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
        S_GAP: begin
          if (gap_q == GC_W'(SYNC_GAP - 1)) state_d = S_IDLE;
          else gap_d = gap_q + GC_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
    // A force request wins over the end-of-frame clear of the same channel
    if (force_update) force_d = '1;
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      written_q <= '0;
      force_q   <= '1;
      frame_q   <= '0;
      ch_q      <= '0;
      bit_idx_q <= '0;
      gap_q     <= '0;
      sclk_q    <= 1'b1;
      sdata_q   <= 1'b0;
      sync_q    <= 1'b1;
      done_q    <= 1'b0;
      last_q    <= 3'(N_CH - 1);
    end else begin
      state_q   <= state_d;
      data_q    <= data_in;
      written_q <= written_d;
      force_q   <= force_d;
      frame_q   <= frame_d;
      ch_q      <= ch_d;
      bit_idx_q <= bit_idx_d;
      gap_q     <= gap_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      sync_q    <= sync_d;
      done_q    <= done_d;
      last_q    <= last_d;
    end
  end

  assign sclk       = sclk_q;
  assign sdata      = sdata_q;
  assign sync       = sync_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign last_ch    = last_q;

endmodule

// File: tb/tb_dac_spi_multi.sv
// Bench for dac_spi_multi (N_CH=2, CLK_DIV=2, SYNC_GAP=2): a pin monitor
// decodes frames off sync/sclk/sdata, and the expected frame lists come
// from a vector table plus a few timed corner-case sequences.
module tb_dac_spi_multi;

  localparam int CLKD = 2;
  localparam int LOWC = (2 * 24 + 1) * CLKD;  // sync-low cycles per frame
  localparam int PERC = 2 * CLKD;              // sclk period in cycles
  localparam int GAPC = (2 + 1) * CLKD;        // shortest sync-high stretch

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d0 = 16'hABCD, d1 = 16'h1234;
  logic        frc = 1'b0;
  logic        sclk, sdata, sync, busy, frame_done;
  logic [2:0]  last_ch;

  dac_spi_multi #(.N_CH(2), .DATA_W(16), .CMD_W(8), .CMD_BASE('h10),
                  .CLK_DIV(CLKD), .SYNC_GAP(2)) dut (
    .clk_100M(clk), .rst(rst), .data_in({d1, d0}), .force_update(frc),
    .sclk(sclk), .sdata(sdata), .sync(sync), .busy(busy),
    .frame_done(frame_done), .last_ch(last_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] val;
    int bits, lowc, minp, maxp, highc;
  } frm_t;

  frm_t        frames[$];
  int          done_cnt = 0;
  int          n_chk = 0, n_pass = 0;

  // pin monitor state
  logic        p_sync = 1'bx, p_sclk = 1'bx;
  logic [23:0] m_sh;
  int          m_bits = 0, m_low = 0, m_per = 0, m_minp = 0, m_maxp = 0;
  int          m_high = 0, m_curhigh = 0;

  always @(negedge clk) begin
    if (sync === 1'b0) begin
      if (p_sync === 1'b1) begin
        m_curhigh = m_high; m_low = 0; m_bits = 0; m_sh = '0;
        m_per = 0; m_minp = 1000; m_maxp = 0;
      end
      m_low++; m_per++;
      if (p_sclk === 1'b1 && sclk === 1'b0) begin
        m_sh = {m_sh[22:0], sdata};
        m_bits++;
        if (m_bits > 1) begin
          if (m_per < m_minp) m_minp = m_per;
          if (m_per > m_maxp) m_maxp = m_per;
        end
        m_per = 0;
      end
    end else begin
      if (p_sync === 1'b0) begin
        frames.push_back('{m_sh, m_bits, m_low, m_minp, m_maxp, m_curhigh});
        m_high = 0;
      end
      m_high++;
    end
    if (frame_done === 1'b1) done_cnt++;
    p_sync = sync; p_sclk = sclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic seg_start();
    frames.delete();
    done_cnt = 0;
  endtask

  task automatic chk_frame(input string tag, input int i, input logic [23:0] exp);
    if (frames.size() > i) begin
      chk({tag, " value"}, 32'(frames[i].val), 32'(exp));
      chk({tag, " bits"},  32'(frames[i].bits), 32'd24);
      chk({tag, " synclow"}, 32'(frames[i].lowc), 32'(LOWC));
      chk({tag, " sclkper"}, {16'(frames[i].minp), 16'(frames[i].maxp)},
          {16'(PERC), 16'(PERC)});
    end
  endtask

  task automatic wait_sync_low(input string tag);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      if (sync === 1'b0) ok = 1;
    end
    chk({tag, " sync fall timeout"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [15:0] d1, d0;
    bit          frc;
    int          nf;
    logic [23:0] f0, f1;
    logic [2:0]  lc;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{16'h1234, 16'hABCD, 0, 2, 24'h10ABCD, 24'h111234, 3'd1};
    vt[1] = '{16'h0001, 16'hABCD, 0, 1, 24'h110001, 24'h0,      3'd1};
    vt[2] = '{16'h0001, 16'hABCD, 1, 2, 24'h10ABCD, 24'h110001, 3'd1};
    vt[3] = '{16'h7777, 16'h5555, 0, 2, 24'h105555, 24'h117777, 3'd1};
    vt[4] = '{16'h7777, 16'h5555, 0, 0, 24'h0,      24'h0,      3'd1};
    vt[5] = '{16'h0000, 16'hFFFF, 0, 2, 24'h10FFFF, 24'h110000, 3'd1};
    vt[6] = '{16'h0000, 16'h1111, 0, 1, 24'h101111, 24'h0,      3'd0};
    vt[7] = '{16'hBEEF, 16'hCAFE, 0, 2, 24'h11BEEF, 24'h10CAFE, 3'd0};

    // reset state
    cyc(4);
    chk("reset pins", {26'd0, sclk, sync, sdata, busy, frame_done, 1'b0},
        {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset last_ch", 32'(last_ch), 32'd1);
    seg_start();
    rst = 1'b0;

    // table-driven vectors
    for (int v = 0; v < 8; v++) begin
      string t;
      t = $sformatf("vec%0d", v);
      if (v > 0) seg_start();
      d1 = vt[v].d1; d0 = vt[v].d0;
      if (vt[v].frc) begin frc = 1'b1; cyc(1); frc = 1'b0; end
      cyc(400);
      chk({t, " nframes"}, 32'(frames.size()), 32'(vt[v].nf));
      chk({t, " done pulses"}, 32'(done_cnt), 32'(vt[v].nf));
      if (vt[v].nf > 0) chk_frame({t, " f0"}, 0, vt[v].f0);
      if (vt[v].nf > 1) chk_frame({t, " f1"}, 1, vt[v].f1);
      chk({t, " last_ch"}, 32'(last_ch), 32'(vt[v].lc));
      chk({t, " idle"}, {31'd0, busy}, 32'd0);
    end

    // change ch0 in the middle of a ch1 frame
    seg_start();
    d1 = 16'h2222;
    wait_sync_low("midchg");
    cyc(40);
    d0 = 16'h5555;
    cyc(400);
    chk("midchg nframes", 32'(frames.size()), 32'd2);
    chk_frame("midchg f0", 0, 24'h112222);
    chk_frame("midchg f1", 1, 24'h105555);
    if (frames.size() > 1) chk("midchg gap", 32'(frames[1].highc), 32'(GAPC));

    // ch0 toggles away and back while ch1 is being written: no ch0 frame
    seg_start();
    d1 = 16'h3333;
    wait_sync_low("toggle");
    cyc(10);
    d0 = 16'h9999;
    cyc(3);
    d0 = 16'h5555;
    cyc(400);
    chk("toggle nframes", 32'(frames.size()), 32'd1);
    chk_frame("toggle f0", 0, 24'h113333);

    // force_update lands on the same edge as the end-of-frame clear
    seg_start();
    d1 = 16'h4444;
    wait_sync_low("forceend");
    cyc(LOWC - 1);
    frc = 1'b1;
    cyc(1);
    frc = 1'b0;
    chk("forceend done", {31'd0, frame_done}, 32'd1);
    cyc(450);
    chk("forceend nframes", 32'(frames.size()), 32'd3);
    chk_frame("forceend f0", 0, 24'h114444);
    chk_frame("forceend f1", 1, 24'h105555);
    chk_frame("forceend f2", 2, 24'h114444);
    chk("forceend last_ch", 32'(last_ch), 32'd1);

    // reset at bit 10 of a frame
    seg_start();
    d0 = 16'h6666;
    wait_sync_low("midrst");
    for (int i = 0; i < 200 && m_bits < 10; i++) cyc(1);
    chk("midrst reached bit10", 32'(m_bits), 32'd10);
    rst = 1'b1;
    cyc(1);
    chk("midrst pins", {29'd0, sync, sclk, busy}, {29'd0, 1'b1, 1'b1, 1'b0});
    rst = 1'b0;
    seg_start();
    cyc(400);
    chk("midrst nframes", 32'(frames.size()), 32'd2);
    chk_frame("midrst f0", 0, 24'h106666);
    chk_frame("midrst f1", 1, 24'h114444);

    // dense random input stream
    begin
      logic [15:0] mw0, mw1;
      int bad_shape = 0, bad_gap = 0, bad_cmd = 0;
      mw0 = 16'h6666; mw1 = 16'h4444;
      seg_start();
      for (int i = 0; i < 600; i++) begin
        cyc(1);
        if ($urandom_range(0, 2) == 0) d0 = 16'($urandom);
        if ($urandom_range(0, 2) == 0) d1 = 16'($urandom);
      end
      cyc(500);
      foreach (frames[i]) begin
        if (frames[i].bits != 24 || frames[i].lowc != LOWC ||
            frames[i].minp != PERC || frames[i].maxp != PERC) bad_shape++;
        if (i > 0 && frames[i].highc < GAPC) bad_gap++;
        if (frames[i].val[23:16] == 8'h10) mw0 = frames[i].val[15:0];
        else if (frames[i].val[23:16] == 8'h11) mw1 = frames[i].val[15:0];
        else bad_cmd++;
      end
      chk("rand some frames", 32'(frames.size() > 5), 32'd1);
      chk("rand frame shape", 32'(bad_shape), 32'd0);
      chk("rand sync gap", 32'(bad_gap), 32'd0);
      chk("rand cmd", 32'(bad_cmd), 32'd0);
      chk("rand done pulses", 32'(done_cnt), 32'(frames.size()));
      chk("rand written ch0", 32'(mw0), 32'(d0));
      chk("rand written ch1", 32'(mw1), 32'(d1));
      chk("rand idle", {31'd0, busy}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
